lock_code_fsm: RTL and testbench

//  Combination-lock controller downstream of rate_divider: consumes its 1-cycle
//  `tick` (time base) and 4-bit hex digit, collects a 4-digit entry on `enter`

---
 rtl/lock_code_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_lock_code_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_fsm.sv
// lock_code_fsm
//   Combination-lock controller driven by the 1-cycle tick from rate_divider.
//   Collects four hex digits on enter pulses, compares them against the stored
//   code, then either opens for a number of ticks or counts a failure. Enough
//   consecutive failures cause a lockout lasting a number of ticks. Every
//   timeout and duration counts ticks, never raw clocks.
//
//   Optional feature macro: PROGRAMMABLE_CODE_EN
//     When defined, a set_code input is added. Pulsing it while open enters a
//     programming state in which the next four digits replace the code.
//
// Ports
//   CLOCK_50   in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   tick       in   1-cycle time base pulse
//   digit      in   4-bit hex digit, sampled when enter=1
//   enter      in   1-cycle pulse: accept digit
//   clear      in   1-cycle pulse: abort entry / relock
//   set_code   in   (PROGRAMMABLE_CODE_EN only) start code programming in OPEN
//   unlocked   out  high while open (and while programming)
//   lockout    out  high while locked out
//   error      out  1-cycle pulse during the check cycle of a mismatch
//   digit_cnt  out  digits accepted in the current entry (0..4)
//   fail_cnt   out  consecutive mismatches, saturating at MAX_FAILS
module lock_code_fsm #(
  parameter logic [15:0] CODE          = 16'h1234,
  parameter int          TIMEOUT_TICKS = 10,
  parameter int          OPEN_TICKS    = 5,
  parameter int          MAX_FAILS     = 3,
  parameter int          LOCKOUT_TICKS = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
`ifdef PROGRAMMABLE_CODE_EN
  input  logic       set_code,
`endif
  output logic       unlocked,
  output logic       lockout,
  output logic       error,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  // Terminal counts are compared against the pre-increment counter value, so
  // the tick that makes the count reach N is the one that leaves the state.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] OpenLast    = 8'(OPEN_TICKS - 1);
  localparam logic [7:0] LockoutLast = 8'(LOCKOUT_TICKS - 1);
  localparam logic [1:0] MaxFails    = 2'(MAX_FAILS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
`ifdef PROGRAMMABLE_CODE_EN
    , ST_PROG
`endif
  } state_e;

  state_e      state_q;
  logic [15:0] entry_q;
  logic [7:0]  tickCnt_q;
  logic [2:0]  digitCnt_q;
  logic [1:0]  failCnt_q;
  logic        unlocked_q;
  logic        lockout_q;
  logic        error_q;
  logic [15:0] activeCode;
  logic [15:0] entryShift_d;

`ifdef PROGRAMMABLE_CODE_EN
  logic [15:0] code_q;
  assign activeCode = code_q;
`else
  assign activeCode = CODE;
`endif

  assign entryShift_d = {entry_q[11:0], digit};

  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;
  assign error     = error_q;
  assign digit_cnt = digitCnt_q;
  assign fail_cnt  = failCnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      entry_q    <= 16'h0000;
      tickCnt_q  <= 8'd0;
      digitCnt_q <= 3'd0;
      failCnt_q  <= 2'd0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      error_q    <= 1'b0;
`ifdef PROGRAMMABLE_CODE_EN
      code_q     <= CODE;
`endif
    end else begin
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            digitCnt_q <= 3'd0;
            entry_q    <= 16'h0000;
          end else if (enter) begin
            entry_q    <= {12'h000, digit};
            digitCnt_q <= 3'd1;
            tickCnt_q  <= 8'd0;
            state_q    <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (clear) begin
            digitCnt_q <= 3'd0;
            entry_q    <= 16'h0000;
            tickCnt_q  <= 8'd0;
            state_q    <= ST_IDLE;
          end else if (enter) begin
            entry_q    <= entryShift_d;
            digitCnt_q <= digitCnt_q + 3'd1;
            tickCnt_q  <= 8'd0;
            if (digitCnt_q == 3'd3) begin
              // The error pulse is registered here so it is high during CHECK.
              error_q <= (entryShift_d != activeCode);
              state_q <= ST_CHECK;
            end
          end else if (tick) begin
            if (tickCnt_q == TimeoutLast) begin
              digitCnt_q <= 3'd0;
              entry_q    <= 16'h0000;
              tickCnt_q  <= 8'd0;
              state_q    <= ST_IDLE;
            end else begin
              tickCnt_q <= tickCnt_q + 8'd1;
            end
          end
        end

        ST_CHECK: begin
          digitCnt_q <= 3'd0;
          entry_q    <= 16'h0000;
          tickCnt_q  <= 8'd0;
          if (entry_q == activeCode) begin
            failCnt_q  <= 2'd0;
            unlocked_q <= 1'b1;
            state_q    <= ST_OPEN;
          end else begin
            failCnt_q <= failCnt_q + 2'd1;
            if ((failCnt_q + 2'd1) == MaxFails) begin
              lockout_q <= 1'b1;
              state_q   <= ST_LOCKOUT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_OPEN: begin
          if (clear) begin
            unlocked_q <= 1'b0;
            tickCnt_q  <= 8'd0;
            state_q    <= ST_IDLE;
`ifdef PROGRAMMABLE_CODE_EN
          end else if (set_code) begin
            tickCnt_q  <= 8'd0;
            digitCnt_q <= 3'd0;
            entry_q    <= 16'h0000;
            state_q    <= ST_PROG;
`endif
          end else if (tick) begin
            if (tickCnt_q == OpenLast) begin
              unlocked_q <= 1'b0;
              tickCnt_q  <= 8'd0;
              state_q    <= ST_IDLE;
            end else begin
              tickCnt_q <= tickCnt_q + 8'd1;
            end
          end
        end

        ST_LOCKOUT: begin
          if (tick) begin
            if (tickCnt_q == LockoutLast) begin
              lockout_q <= 1'b0;
              failCnt_q <= 2'd0;
              tickCnt_q <= 8'd0;
              state_q   <= ST_IDLE;
            end else begin
              tickCnt_q <= tickCnt_q + 8'd1;
            end
          end
        end

`ifdef PROGRAMMABLE_CODE_EN
        // Programming reuses the entry shifter; the code register only
        // changes once all four digits have arrived, so an abort keeps it.
        ST_PROG: begin
          if (clear) begin
            unlocked_q <= 1'b0;
            digitCnt_q <= 3'd0;
            entry_q    <= 16'h0000;
            tickCnt_q  <= 8'd0;
            state_q    <= ST_IDLE;
          end else if (enter) begin
            tickCnt_q <= 8'd0;
            if (digitCnt_q == 3'd3) begin
              code_q     <= entryShift_d;
              unlocked_q <= 1'b0;
              digitCnt_q <= 3'd0;
              entry_q    <= 16'h0000;
              state_q    <= ST_IDLE;
            end else begin
              entry_q    <= entryShift_d;
              digitCnt_q <= digitCnt_q + 3'd1;
            end
          end else if (tick) begin
            if (tickCnt_q == TimeoutLast) begin
              unlocked_q <= 1'b0;
              digitCnt_q <= 3'd0;
              entry_q    <= 16'h0000;
              tickCnt_q  <= 8'd0;
              state_q    <= ST_IDLE;
            end else begin
              tickCnt_q <= tickCnt_q + 8'd1;
            end
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_code_fsm.sv
// tb_lock_code_fsm
//   Directed bench for lock_code_fsm. Expected output values are queued as
//   stimulus is applied and drained against the DUT outputs after each step.
module tb_lock_code_fsm;

  logic       CLOCK_50;
  logic       reset;
  logic       tick;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
`ifdef PROGRAMMABLE_CODE_EN
  logic       set_code;
`endif
  logic       unlocked;
  logic       lockout;
  logic       error;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] exp;
  } exp_t;

  exp_t scoreboard[$];

  lock_code_fsm dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick),
    .digit    (digit),
    .enter    (enter),
    .clear    (clear),
`ifdef PROGRAMMABLE_CODE_EN
    .set_code (set_code),
`endif
    .unlocked (unlocked),
    .lockout  (lockout),
    .error    (error),
    .digit_cnt(digit_cnt),
    .fail_cnt (fail_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One clock step: inputs are changed and outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic en,
                               input logic clr, input logic tk);
    digit = d;
    enter = en;
    clear = clr;
    tick  = tk;
    cycle();
    enter = 1'b0;
    clear = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    applyStimulus(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pushExp(input string tag, input int field, input logic [7:0] v);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.exp   = v;
    scoreboard.push_back(e);
  endtask

  // Fields: 0 unlocked, 1 lockout, 2 error, 3 digit_cnt, 4 fail_cnt.
  task automatic expectAll(input string tag, input logic u, input logic l,
                           input logic e, input logic [2:0] dc, input logic [1:0] fc);
    pushExp({tag, ".unlocked"}, 0, {7'd0, u});
    pushExp({tag, ".lockout"},  1, {7'd0, l});
    pushExp({tag, ".error"},    2, {7'd0, e});
    pushExp({tag, ".digit_cnt"}, 3, {5'd0, dc});
    pushExp({tag, ".fail_cnt"}, 4, {6'd0, fc});
  endtask

  function automatic logic [7:0] observed(input int field);
    case (field)
      0:       return {7'd0, unlocked};
      1:       return {7'd0, lockout};
      2:       return {7'd0, error};
      3:       return {5'd0, digit_cnt};
      4:       return {6'd0, fail_cnt};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic [7:0] obs;
    while (scoreboard.size() > 0) begin
      e   = scoreboard.pop_front();
      obs = observed(e.field);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    digit = 4'h0;
    enter = 1'b0;
    clear = 1'b0;
`ifdef PROGRAMMABLE_CODE_EN
    set_code = 1'b0;
`endif
    cycle();
    cycle();
    reset = 1'b0;
    expectAll("reset", 0, 0, 0, 3'd0, 2'd0);
    checkOutput();

    // Correct code: opens two clocks after the 4th digit, closes after 5 ticks.
    $display("[TB] correct code");
    press(4'h1); pushExp("t1.dc1", 3, 8'd1); checkOutput();
    press(4'h2); press(4'h3); pushExp("t1.dc3", 3, 8'd3); checkOutput();
    press(4'h4); expectAll("t1.check", 0, 0, 0, 3'd4, 2'd0); checkOutput();
    cycle();     expectAll("t1.open", 1, 0, 0, 3'd0, 2'd0); checkOutput();
    press(4'h7); pushExp("t1.enterIgnored", 3, 8'd0); checkOutput();
    ticks(4);    pushExp("t1.open4", 0, 8'd1); checkOutput();
    ticks(1);    pushExp("t1.closed", 0, 8'd0); checkOutput();

    // Three mismatches lead to lockout lasting 20 ticks.
    $display("[TB] lockout");
    for (int r = 1; r <= 3; r++) begin
      press(4'h1); press(4'h2); press(4'h3); press(4'h5);
      expectAll($sformatf("t2.check%0d", r), 0, 0, 1, 3'd4, 2'(r - 1));
      checkOutput();
      cycle();
      expectAll($sformatf("t2.after%0d", r), 0, (r == 3), 0, 3'd0, 2'(r));
      checkOutput();
    end
    press(4'h1); press(4'h2);
    expectAll("t2.ignored", 0, 1, 0, 3'd0, 2'd3); checkOutput();
    ticks(19);   pushExp("t2.lock19", 1, 8'd1); checkOutput();
    ticks(1);    expectAll("t2.release", 0, 0, 0, 3'd0, 2'd0); checkOutput();

    // Timeout discards entry without counting a fail; enter restarts the count.
    $display("[TB] timeout");
    press(4'h9); press(4'h9); press(4'h9); press(4'h9); cycle();
    pushExp("t3.fail1", 4, 8'd1); checkOutput();
    press(4'h1); press(4'h2);
    ticks(9);    pushExp("t3.tick9", 3, 8'd2); checkOutput();
    ticks(1);    expectAll("t3.timeout", 0, 0, 0, 3'd0, 2'd1); checkOutput();
    press(4'h1); press(4'h2);
    ticks(8);
    applyStimulus(4'h3, 1'b1, 1'b0, 1'b1);
    pushExp("t3.enterTick", 3, 8'd3); checkOutput();
    ticks(9);    pushExp("t3.restart9", 3, 8'd3); checkOutput();
    ticks(1);    pushExp("t3.restartTo", 3, 8'd0); pushExp("t3.failKept", 4, 8'd1);
    checkOutput();

    // clear beats enter; reset mid-entry returns everything to zero.
    $display("[TB] clear and reset");
    press(4'h1); press(4'h2); press(4'h3);
    applyStimulus(4'h4, 1'b1, 1'b1, 1'b0);
    expectAll("t4.clear", 0, 0, 0, 3'd0, 2'd1); checkOutput();
    press(4'h1); press(4'h2); press(4'h3);
    reset = 1'b1; cycle(); reset = 1'b0;
    expectAll("t4.reset", 0, 0, 0, 3'd0, 2'd0); checkOutput();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); cycle();
    pushExp("t4.open", 0, 8'd1); checkOutput();
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    pushExp("t4.relock", 0, 8'd0); checkOutput();

    // One mismatch then the right code clears the fail count.
    $display("[TB] recover after mismatch");
    press(4'h4); press(4'h3); press(4'h2); press(4'h1); cycle();
    pushExp("t5.fail1", 4, 8'd1); checkOutput();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); cycle();
    expectAll("t5.open", 1, 0, 0, 3'd0, 2'd0); checkOutput();

`ifdef PROGRAMMABLE_CODE_EN
    // Reprogram the code to ABCD while open.
    $display("[TB] programmable code");
    set_code = 1'b1; cycle(); set_code = 1'b0;
    expectAll("t6.prog", 1, 0, 0, 3'd0, 2'd0); checkOutput();
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    expectAll("t6.stored", 0, 0, 0, 3'd0, 2'd0); checkOutput();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    pushExp("t6.oldCode", 2, 8'd1); checkOutput();
    cycle();
    press(4'hA); press(4'hB); press(4'hC); press(4'hD); cycle();
    expectAll("t6.newCode", 1, 0, 0, 3'd0, 2'd0); checkOutput();
`else
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    pushExp("t6.relock", 0, 8'd0); checkOutput();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
